// File: rtl/wb_uart_tx_pkg.sv
// wb_uart_tx shared definitions:
// register map, STATUS layout, FSM states.
package wb_uart_tx_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_LVL_LO = 8;
  localparam int ST_LVL_HI = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/wb_uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO, power-of-two depth,
// pointers wrap naturally, explicit level counter.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = level == LW'(DEPTH);
  assign empty = level == '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push && !pop: level <= level + 1'b1;
        pop && !push: level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone B4 classic slave driving
// an 8N1 UART transmitter fed by a byte FIFO.
module wb_uart_tx
  import wb_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 24000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        uart_tx_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / BAUD);

  tx_state_e   state;
  logic [15:0] div;
  logic [15:0] div_lat;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        ovf;

  logic          req;
  logic [1:0]    reg_sel;
  logic          wr_data;
  logic          wr_stat;
  logic          wr_div;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          full;
  logic          empty;
  logic [7:0]    fifo_dout;
  logic [LW-1:0] level;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:2],
                         wb_dat_i[31:16]};

  // one ack per access; the ack cycle blocks a new request
  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign reg_sel = wb_adr_i[3:2];
  assign wr_data = req & wb_we_i & (reg_sel == REG_DATA)
                 & wb_sel_i[0];
  assign wr_stat = req & wb_we_i & (reg_sel == REG_STATUS);
  assign wr_div  = req & wb_we_i & (reg_sel == REG_DIV)
                 & (&wb_sel_i[1:0]);

  assign pop = ~empty & ((state == S_IDLE) |
               ((state == S_STOP) & (cnt == '0)));
  assign push    = wr_data & (~full | pop);
  assign ovf_set = wr_data & full & ~pop;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (wb_clk_i),
    .rst_n(wb_rst_n_i),
    .push (push),
    .din  (wb_dat_i[7:0]),
    .pop  (pop),
    .dout (fifo_dout),
    .full (full),
    .empty(empty),
    .level(level)
  );

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      reg_sel == REG_STATUS: begin
        rdata[ST_FULL]  = full;
        rdata[ST_EMPTY] = empty;
        rdata[ST_BUSY]  = state != S_IDLE;
        rdata[ST_OVF]   = ovf;
        rdata[ST_LVL_HI:ST_LVL_LO] = 5'(level);
      end
      reg_sel == REG_DIV: rdata[15:0] = div;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      div      <= DIV_RST;
      ovf      <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req ? rdata : '0;
      if (wr_div)
        div <= (wb_dat_i[15:0] == '0) ? 16'd1
                                      : wb_dat_i[15:0];
      // a failed push wins over a same-edge clear
      if (ovf_set)
        ovf <= 1'b1;
      else if (wr_stat && wb_dat_i[ST_OVF])
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= S_IDLE;
      uart_tx_o <= 1'b1;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      div_lat   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          uart_tx_o <= 1'b1;
          if (pop) begin
            state     <= S_START;
            uart_tx_o <= 1'b0;
            shreg     <= fifo_dout;
            div_lat   <= div;
            cnt       <= div - 16'd1;
            idx       <= '0;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            state     <= S_DATA;
            uart_tx_o <= shreg[0];
            shreg     <= shreg >> 1;
            idx       <= '0;
            cnt       <= div_lat - 16'd1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            cnt <= div_lat - 16'd1;
            if (idx == 3'd7) begin
              state     <= S_STOP;
              uart_tx_o <= 1'b1;
            end else begin
              idx       <= idx + 3'd1;
              uart_tx_o <= shreg[0];
              shreg     <= shreg >> 1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (cnt == '0) begin
            // back-to-back frames: no idle cycle
            if (pop) begin
              state     <= S_START;
              uart_tx_o <= 1'b0;
              shreg     <= fifo_dout;
              div_lat   <= div;
              cnt       <= div - 16'd1;
              idx       <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_uart_tx.md
WB_UART_TX -- requirements
Module: wb_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 24000000, wb_clk_i frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, reset baud rate; reset divisor DIV_RST = CLK_FREQ/BAUD, integer-truncated (208 at defaults).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries; power of two, 2..16.
REQ-004 SHALL have port wb_clk_i  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port wb_adr_i  in  4  byte address; only [3:2] decoded.
REQ-007 SHALL have port wb_dat_i  in  32  write data.
REQ-008 SHALL have port wb_sel_i  in  4  byte lanes; lane 0 required for DATA writes, lanes 0-1 for DIV writes.
REQ-009 SHALL have ports wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  Wishbone B4 classic cycle controls.
REQ-010 SHALL have port wb_dat_o  out  32  read data.
REQ-011 SHALL have port wb_ack_o  out  1  single-cycle acknowledge.
REQ-012 SHALL have port uart_tx_o  out  1  serial line, 8N1, idle high.

Function
REQ-013 SHALL decode registers: 0x0 DATA (W; read returns 0), 0x4 STATUS (R/W1C), 0x8 DIV (R/W, bits [15:0]), 0xC reserved (read 0, write ignored).
REQ-014 SHALL define STATUS as: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[12:8] FIFO level; all other bits 0.
REQ-015 SHALL register wb_ack_o high for exactly one cycle, on the edge after wb_cyc_i&wb_stb_i are first sampled high; no ack is issued in the cycle following an ack, giving a 2-cycle minimum per access.
REQ-016 SHALL perform register write side effects on the same edge that sets wb_ack_o; wb_dat_o SHALL be valid while wb_ack_o is high.
REQ-017 SHALL push wb_dat_i[7:0] into the FIFO on a DATA write with wb_sel_i[0]=1 when not full; when full, SHALL drop the byte, set overflow, and still ack.
REQ-018 SHALL clear overflow only on a STATUS write with wb_dat_i[3]=1; a push-attempt-when-full coinciding with the clear SHALL leave overflow set.
REQ-019 SHALL treat a DIV write of 0 as 1.
REQ-020 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-021 IDLE: uart_tx_o=1; when FIFO is non-empty, SHALL pop one byte, latch the current DIV, go to START, and drive uart_tx_o=0 from that edge.
REQ-022 Each bit SHALL last exactly latched-DIV cycles, timed by a down-counter reloaded at every bit boundary.
REQ-023 START -> DATA after one bit time; DATA SHALL send 8 bits LSB first using a 3-bit index, then go to STOP; STOP drives 1 for one bit time.
REQ-024 From STOP, when FIFO is non-empty, SHALL go directly to START (pop and latch DIV) with no idle cycle; otherwise SHALL go to IDLE.
REQ-025 A write to DATA at edge N with FIFO empty and FSM IDLE SHALL drive uart_tx_o low after edge N+1.
REQ-026 DIV writes mid-frame SHALL take effect at the next frame only.
REQ-027 A simultaneous FIFO push and pop SHALL leave the level unchanged, including when full (pop frees the slot, push accepted, no overflow).
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level SHALL be held in a counter of width log2(FIFO_DEPTH)+1.

Reset
REQ-029 Asserting wb_rst_n_i low SHALL immediately set: uart_tx_o=1, wb_ack_o=0, wb_dat_o=0, FSM=IDLE, FIFO empty, level=0, overflow=0, DIV=DIV_RST, bit counter and index=0.
REQ-030 Reset mid-frame SHALL abort the frame; the line returns high without a stop bit, and queued bytes are discarded.
REQ-031 Release SHALL be synchronised externally; after release, the block SHALL accept an access on the first sampled edge.

Structure
REQ-032 Package wb_uart_tx_pkg SHALL hold register offsets, STATUS bit positions, and the FSM state enum.
REQ-033 The FIFO SHALL be a sub-module uart_tx_fifo (parameter DEPTH, width 8, push/pop/full/empty/level outputs).

Verification
REQ-034 Reset, then write 0x55 to DATA at default DIV -> uart_tx_o sequence 0,1,0,1,0,1,0,1,0,1, each bit 208 cycles; frame 2080 cycles; busy=1 during the frame; empty=1 after the pop.
REQ-035 Write 9 bytes back-to-back while idle -> byte 1 pops, 8 are queued, and no overflow; a 10th byte written while full sets overflow=1; a STATUS write of 0x8 clears it.
REQ-036 Write DIV=4, then bytes 0xA3 and 0x0F -> each bit lasts 4 cycles, the second start bit immediately follows the first stop bit, and the line shows no extra idle cycle.
REQ-037 Write DIV=0 then read DIV -> reads 1; a frame sends 1-cycle bits. Write DIV=10 mid-frame -> the current frame keeps the old timing and the next frame uses 10.
REQ-038 Assert wb_rst_n_i during data bit 3 with 3 bytes queued -> uart_tx_o goes high asynchronously; STATUS reads 0x00000002 and DIV reads 208 after release.
REQ-039 Read 0xC and read DATA -> 0x00000000; verify one ack per access and that wb_ack_o never stays high for 2 consecutive cycles under held stb.
